// File: rtl/rpn_operand_datapath_if.sv
// Bundle between the RPN control FSM / switch bus and the operand datapath.
// The master drives the strobes and the switch bus, and the slave returns the stored state.
interface rpn_operand_datapath_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] DataIn;
  logic             LoadOpA;
  logic             LoadOpB;
  logic             LoadOpCode;
  logic             updateRes;
  logic             ToDisplaySel;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [2:0]       OpCode;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flags;
  logic             ResultValid;
  logic [WIDTH-1:0] DisplayValue;

  modport master (
    output DataIn, LoadOpA, LoadOpB, LoadOpCode, updateRes, ToDisplaySel,
    input  OpA, OpB, OpCode, Result, Flags, ResultValid, DisplayValue
  );

  modport slave (
    input  DataIn, LoadOpA, LoadOpB, LoadOpCode, updateRes, ToDisplaySel,
    output OpA, OpB, OpCode, Result, Flags, ResultValid, DisplayValue
  );
endinterface

// File: rtl/rpn_operand_datapath.sv
// Operand/opcode capture, registered ALU with {N,Z,C,V} flags, and display mux
// for the reverse-polish calculator.
module rpn_operand_datapath #(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  reset,
  rpn_operand_datapath_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] opAReg;
  logic [WIDTH-1:0] opBReg;
  logic [2:0]       opCodeReg;
  logic [WIDTH-1:0] resultReg;
  logic [3:0]       flagsReg;
  logic             validReg;
  logic [WIDTH-1:0] displayReg;

  logic             anyStrobe;
  logic             leaveCalc;
  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   subSum;
  logic [WIDTH:0]   shlWide;
  logic [WIDTH:0]   shrWide;
  logic [SHW-1:0]   shiftAmt;
  logic [WIDTH-1:0] aluRes;
  logic             aluC;
  logic             aluV;

  assign anyStrobe = bus.LoadOpA | bus.LoadOpB | bus.LoadOpCode | bus.updateRes;
  // Any strobe seen while in CALC keeps us there, so the result always reflects the latest operands.
  assign leaveCalc = (state == CALC) && !anyStrobe;

  assign shiftAmt = opBReg[SHW-1:0];
  assign addSum   = {1'b0, opAReg} + {1'b0, opBReg};
  assign subSum   = {1'b0, opAReg} + {1'b0, ~opBReg} + {{WIDTH{1'b0}}, 1'b1};
  // The extra guard bit on each side catches the last bit shifted out, which stays 0 when the amount is 0.
  assign shlWide  = {1'b0, opAReg} << shiftAmt;
  assign shrWide  = {opAReg, 1'b0} >> shiftAmt;

  always_comb begin
    aluRes = opAReg;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (opCodeReg)
      3'b000: begin
        aluRes = addSum[WIDTH-1:0];
        aluC   = addSum[WIDTH];
        aluV   = (opAReg[WIDTH-1] == opBReg[WIDTH-1]) &&
                 (addSum[WIDTH-1] != opAReg[WIDTH-1]);
      end
      3'b001: begin
        aluRes = subSum[WIDTH-1:0];
        aluC   = subSum[WIDTH];
        aluV   = (opAReg[WIDTH-1] != opBReg[WIDTH-1]) &&
                 (subSum[WIDTH-1] != opAReg[WIDTH-1]);
      end
      3'b010: aluRes = opAReg & opBReg;
      3'b011: aluRes = opAReg | opBReg;
      3'b100: aluRes = opAReg ^ opBReg;
      3'b101: begin
        aluRes = shlWide[WIDTH-1:0];
        aluC   = shlWide[WIDTH];
      end
      3'b110: begin
        aluRes = shrWide[WIDTH:1];
        aluC   = shrWide[0];
      end
      default: aluRes = opAReg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      opAReg     <= '0;
      opBReg     <= '0;
      opCodeReg  <= 3'b000;
      resultReg  <= '0;
      flagsReg   <= 4'b0100;
      validReg   <= 1'b0;
      displayReg <= '0;
    end else begin
      if (bus.LoadOpA)    opAReg    <= bus.DataIn;
      if (bus.LoadOpB)    opBReg    <= bus.DataIn;
      if (bus.LoadOpCode) opCodeReg <= bus.DataIn[2:0];

      case (state)
        IDLE:    if (bus.LoadOpCode || bus.updateRes) state <= CALC;
        CALC:    if (!anyStrobe) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (leaveCalc) begin
        resultReg <= aluRes;
        flagsReg  <= {aluRes[WIDTH-1], (aluRes == '0), aluC, aluV};
        validReg  <= 1'b1;
      end else if (bus.LoadOpA || bus.LoadOpB || bus.LoadOpCode) begin
        validReg  <= 1'b0;
      end

      displayReg <= bus.ToDisplaySel ? resultReg : bus.DataIn;
    end
  end

  assign bus.OpA          = opAReg;
  assign bus.OpB          = opBReg;
  assign bus.OpCode       = opCodeReg;
  assign bus.Result       = resultReg;
  assign bus.Flags        = flagsReg;
  assign bus.ResultValid  = validReg;
  assign bus.DisplayValue = displayReg;

endmodule
